// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control-token constants, control-code type and lock state.
package tmds_pkg;

  typedef logic [1:0] tmds_ctrl_t;

  typedef enum logic {
    SEARCH,
    LOCKED
  } lock_state_e;

  // Bit 0 is the first bit on the wire.
  localparam logic [9:0] TMDS_TOK_C00 = 10'b1101010100;
  localparam logic [9:0] TMDS_TOK_C01 = 10'b0010101011;
  localparam logic [9:0] TMDS_TOK_C10 = 10'b0101010100;
  localparam logic [9:0] TMDS_TOK_C11 = 10'b1010101011;

endpackage

// File: rtl/tmds_word_align.sv
// Bit-slip window: selects a 10-bit symbol from the current and previous
// deserialized words at the given offset and registers it.
module tmds_word_align (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [9:0] d_i,
  input  logic [3:0] offset_i,
  output logic [9:0] w_o
);

  logic [9:0]  d_prev_q, d_prev_d;
  logic [9:0]  w_q, w_d;
  logic [18:0] window;

  // Offset 9 reaches bit 18 at most, so d_i[9] only matters once it is d_prev.
  always_comb begin
    d_prev_d = d_i;
    window   = {d_i[8:0], d_prev_q};
    case (offset_i)
      4'd0:    w_d = window[9:0];
      4'd1:    w_d = window[10:1];
      4'd2:    w_d = window[11:2];
      4'd3:    w_d = window[12:3];
      4'd4:    w_d = window[13:4];
      4'd5:    w_d = window[14:5];
      4'd6:    w_d = window[15:6];
      4'd7:    w_d = window[16:7];
      4'd8:    w_d = window[17:8];
      4'd9:    w_d = window[18:9];
      default: w_d = window[9:0];
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      d_prev_q <= '0;
      w_q      <= '0;
    end else begin
      d_prev_q <= d_prev_d;
      w_q      <= w_d;
    end
  end

  assign w_o = w_q;

endmodule

// File: rtl/tmds_decoder.sv
// TMDS channel decoder: token-based symbol alignment, lock tracking and 8b/10b data decode.
// Optional TMDS_DECODER_STATS_EN adds a saturating loss-of-lock counter on loss_cnt_o.
module tmds_decoder
  import tmds_pkg::*;
#(
  parameter int unsigned LOCK_TOKENS    = 8,
  parameter int unsigned SEARCH_TIMEOUT = 4096,
  parameter int unsigned LOSS_TIMEOUT   = 65536
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [9:0] d_i,
  output logic       de_o,
  output logic       c1_o,
  output logic       c0_o,
  output logic [7:0] q_o,
  output logic       locked_o,
  output logic [3:0] offset_o
`ifdef TMDS_DECODER_STATS_EN
  ,
  output logic [7:0] loss_cnt_o
`endif
);

  localparam int unsigned TOK_W  = (LOCK_TOKENS > 1)    ? $clog2(LOCK_TOKENS)    : 1;
  localparam int unsigned TMO_W  = (SEARCH_TIMEOUT > 1) ? $clog2(SEARCH_TIMEOUT) : 1;
  localparam int unsigned LOSS_W = (LOSS_TIMEOUT > 1)   ? $clog2(LOSS_TIMEOUT)   : 1;
  localparam logic [TOK_W-1:0]  TOK_LAST  = TOK_W'(LOCK_TOKENS - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(SEARCH_TIMEOUT - 1);
  localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_TIMEOUT - 1);

  lock_state_e       state_q, state_d;
  logic [TOK_W-1:0]  tok_cnt_q, tok_cnt_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic [LOSS_W-1:0] loss_cnt_q, loss_cnt_d;
  logic [3:0]        offset_q, offset_d;
  logic              de_q, de_d;
  tmds_ctrl_t        c_q, c_d;
  logic [7:0]        q_q, q_d;

  logic [9:0]        w;
  logic              is_tok;
  tmds_ctrl_t        tok_code;
  logic [7:0]        dec;
  logic [7:0]        data;

  tmds_word_align u_align (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .d_i      (d_i),
    .offset_i (offset_q),
    .w_o      (w)
  );

  always_comb begin
    is_tok   = 1'b1;
    tok_code = 2'b00;
    case (w)
      TMDS_TOK_C00: tok_code = 2'b00;
      TMDS_TOK_C01: tok_code = 2'b01;
      TMDS_TOK_C10: tok_code = 2'b10;
      TMDS_TOK_C11: tok_code = 2'b11;
      default:      is_tok   = 1'b0;
    endcase

    dec     = w[9] ? ~w[7:0] : w[7:0];
    data    = '0;
    data[0] = dec[0];
    for (int unsigned i = 1; i < 8; i++) begin
      data[i] = w[8] ? (dec[i] ^ dec[i-1]) : ~(dec[i] ^ dec[i-1]);
    end
  end

  always_comb begin
    state_d    = state_q;
    tok_cnt_d  = tok_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    loss_cnt_d = loss_cnt_q;
    offset_d   = offset_q;
    case (state_q)
      SEARCH: begin
        // A qualifying token beats a simultaneous timeout: no slip on lock.
        if (is_tok && tok_cnt_q == TOK_LAST) begin
          state_d    = LOCKED;
          tok_cnt_d  = '0;
          tmo_cnt_d  = '0;
          loss_cnt_d = '0;
        end else if (tmo_cnt_q == TMO_LAST) begin
          offset_d  = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
          tok_cnt_d = '0;
          tmo_cnt_d = '0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
          tok_cnt_d = is_tok ? tok_cnt_q + TOK_W'(1) : '0;
        end
      end
      LOCKED: begin
        if (is_tok) begin
          loss_cnt_d = '0;
        end else if (loss_cnt_q == LOSS_LAST) begin
          state_d    = SEARCH;
          tok_cnt_d  = '0;
          tmo_cnt_d  = '0;
          loss_cnt_d = '0;
        end else begin
          loss_cnt_d = loss_cnt_q + LOSS_W'(1);
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  // Gate on the next state so outputs are already zero in the cycle locked_o drops.
  always_comb begin
    de_d = 1'b0;
    c_d  = 2'b00;
    q_d  = '0;
    if (state_d == LOCKED) begin
      if (is_tok) begin
        c_d = tok_code;
      end else begin
        de_d = 1'b1;
        c_d  = c_q;
        q_d  = data;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= SEARCH;
      tok_cnt_q  <= '0;
      tmo_cnt_q  <= '0;
      loss_cnt_q <= '0;
      offset_q   <= '0;
      de_q       <= 1'b0;
      c_q        <= 2'b00;
      q_q        <= '0;
    end else begin
      state_q    <= state_d;
      tok_cnt_q  <= tok_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      loss_cnt_q <= loss_cnt_d;
      offset_q   <= offset_d;
      de_q       <= de_d;
      c_q        <= c_d;
      q_q        <= q_d;
    end
  end

`ifdef TMDS_DECODER_STATS_EN
  logic [7:0] loss_stat_q, loss_stat_d;

  always_comb begin
    loss_stat_d = loss_stat_q;
    if (state_q == LOCKED && state_d == SEARCH && loss_stat_q != 8'hFF) begin
      loss_stat_d = loss_stat_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) loss_stat_q <= '0;
    else       loss_stat_q <= loss_stat_d;
  end

  assign loss_cnt_o = loss_stat_q;
`endif

  assign de_o     = de_q;
  assign c1_o     = c_q[1];
  assign c0_o     = c_q[0];
  assign q_o      = q_q;
  assign locked_o = (state_q == LOCKED);
  assign offset_o = offset_q;

endmodule

// File: tb/tb_tmds_decoder.sv
// Testbench for tmds_decoder: TMDS-encoded streams at various bit delays, noise and
// resets, checked against a cycle-level reference model plus directed vectors.
module tb_tmds_decoder;

  localparam int unsigned LT = 8;
  localparam int unsigned ST = 512;
  localparam int unsigned LS = 4096;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [9:0] d_i   = '0;
  logic       de_o, c1_o, c0_o, locked_o;
  logic [7:0] q_o;
  logic [3:0] offset_o;
`ifdef TMDS_DECODER_STATS_EN
  logic [7:0] loss_cnt_o;
`endif

  tmds_decoder #(
    .LOCK_TOKENS    (LT),
    .SEARCH_TIMEOUT (ST),
    .LOSS_TIMEOUT   (LS)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .d_i      (d_i),
    .de_o     (de_o),
    .c1_o     (c1_o),
    .c0_o     (c0_o),
    .q_o      (q_o),
    .locked_o (locked_o),
    .offset_o (offset_o)
`ifdef TMDS_DECODER_STATS_EN
    ,
    .loss_cnt_o (loss_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // Reference model state
  int m_prev, m_w, m_off, m_tok, m_tmo, m_loss, m_stats, m_c, m_q;
  bit m_lock, m_de;

  // Source side: encoder disparity, previous symbol, bit delay, line position
  int enc_cnt  = 0;
  int s_prev   = 0;
  int delay    = 0;
  int line_pos = 0;
  bit cap_en   = 0;
  int capq[$];
  int srcq[$];

  function automatic int token_code(input int w);
    case (w)
      'h354:   return 0;
      'h0AB:   return 1;
      'h154:   return 2;
      'h2AB:   return 3;
      default: return -1;
    endcase
  endfunction

  function automatic int popc8(input int v);
    int n = 0;
    for (int i = 0; i < 8; i++) n += (v >> i) & 1;
    return n;
  endfunction

  function automatic int decode_byte(input int w);
    int d, r, b;
    d = ((w >> 9) & 1) ? (~w & 255) : (w & 255);
    r = d & 1;
    for (int i = 1; i < 8; i++) begin
      b = ((d >> i) ^ (d >> (i - 1))) & 1;
      if (((w >> 8) & 1) == 0) b = b ^ 1;
      r = r | (b << i);
    end
    return r;
  endfunction

  task automatic encode(input int b, output int sym);
    int n1, qm, diff, q8, x;
    bit use_xnor;
    n1       = popc8(b);
    use_xnor = (n1 > 4) || (n1 == 4 && (b & 1) == 0);
    qm       = b & 1;
    for (int i = 1; i < 8; i++) begin
      x = ((qm >> (i - 1)) ^ (b >> i)) & 1;
      if (use_xnor) x = x ^ 1;
      qm = qm | (x << i);
    end
    q8   = use_xnor ? 0 : 1;
    diff = 2 * popc8(qm & 255) - 8;
    if (enc_cnt == 0 || diff == 0) begin
      sym     = ((1 - q8) << 9) | (q8 << 8) | (q8 != 0 ? (qm & 255) : (~qm & 255));
      enc_cnt = enc_cnt + (q8 != 0 ? diff : -diff);
    end else if ((enc_cnt > 0 && diff > 0) || (enc_cnt < 0 && diff < 0)) begin
      sym     = (1 << 9) | (q8 << 8) | (~qm & 255);
      enc_cnt = enc_cnt + 2 * q8 - diff;
    end else begin
      sym     = (q8 << 8) | (qm & 255);
      enc_cnt = enc_cnt + diff - 2 * (1 - q8);
    end
  endtask

  task automatic model_step(input bit r, input int d);
    int nw, tc;
    if (r) begin
      m_prev = 0; m_w = 0; m_off = 0; m_tok = 0; m_tmo = 0; m_loss = 0;
      m_stats = 0; m_c = 0; m_q = 0; m_lock = 0; m_de = 0;
    end else begin
      nw = (((d << 10) | m_prev) >> m_off) & 1023;
      tc = token_code(m_w);
      if (!m_lock) begin
        if (tc >= 0 && m_tok == LT - 1) begin
          m_lock = 1; m_tok = 0; m_tmo = 0; m_loss = 0;
        end else if (m_tmo == ST - 1) begin
          m_off = (m_off + 1) % 10; m_tok = 0; m_tmo = 0;
        end else begin
          m_tmo = m_tmo + 1;
          m_tok = (tc >= 0) ? m_tok + 1 : 0;
        end
      end else begin
        if (tc >= 0) m_loss = 0;
        else if (m_loss == LS - 1) begin
          m_lock = 0; m_loss = 0; m_tok = 0; m_tmo = 0;
          if (m_stats < 255) m_stats = m_stats + 1;
        end else m_loss = m_loss + 1;
      end
      if (!m_lock) begin
        m_de = 0; m_c = 0; m_q = 0;
      end else if (tc >= 0) begin
        m_de = 0; m_c = tc; m_q = 0;
      end else begin
        m_de = 1; m_q = decode_byte(m_w);
      end
      m_w    = nw;
      m_prev = d;
    end
  endtask

  task automatic tick(input logic [9:0] d, input bit r);
    bit sbad;
    d_i   = d;
    rst_i = r;
    @(posedge clk_i);
    model_step(r, int'(d));
    #1;
    sbad = 1'b0;
`ifdef TMDS_DECODER_STATS_EN
    sbad = (loss_cnt_o !== 8'(m_stats));
`endif
    n_vec++;
    if (de_o !== m_de || {c1_o, c0_o} !== 2'(m_c) || q_o !== 8'(m_q) ||
        locked_o !== m_lock || offset_o !== 4'(m_off) || sbad) begin
      n_bad++;
      $display("FAIL model t=%0t got de=%b c=%b%b q=%h lock=%b off=%0d, expected de=%b c=%0d q=%h lock=%b off=%0d stats=%0d",
               $time, de_o, c1_o, c0_o, q_o, locked_o, offset_o, m_de, m_c, m_q, m_lock, m_off, m_stats);
    end
    if (cap_en && de_o === 1'b1) capq.push_back(int'(q_o));
  endtask

  task automatic chk(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic send(input bit ctl, input int c, input int b);
    int sym, w;
    if (ctl) begin
      enc_cnt = 0;
      case (c)
        0:       sym = 'h354;
        1:       sym = 'h0AB;
        2:       sym = 'h154;
        default: sym = 'h2AB;
      endcase
    end else begin
      encode(b, sym);
    end
    w      = (((sym << 10) | s_prev) >> (10 - delay)) & 1023;
    s_prev = sym;
    tick(10'(w), 1'b0);
  endtask

  task automatic line_step();
    if (line_pos < 20) send(1'b1, 0, 0);
    else               send(1'b0, 0, int'($urandom_range(0, 255)));
    line_pos = (line_pos + 1) % 60;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) tick(10'h000, 1'b1);
    s_prev = 0; enc_cnt = 0; line_pos = 0;
  endtask

  typedef struct {
    bit ctl;
    int c;
    int b;
    int de;
    int cc;
    int q;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int got, b;
    bit wrapped;
    int prev_off;

    tbl[0] = '{0, 0, 'h00, 1, 0, 'h00};
    tbl[1] = '{0, 0, 'hFF, 1, 0, 'hFF};
    tbl[2] = '{0, 0, 'h55, 1, 0, 'h55};
    tbl[3] = '{0, 0, 'hA3, 1, 0, 'hA3};
    tbl[4] = '{1, 1, 0,    0, 1, 0};
    tbl[5] = '{0, 0, 'h3C, 1, 1, 'h3C};
    tbl[6] = '{1, 3, 0,    0, 3, 0};
    tbl[7] = '{1, 2, 0,    0, 2, 0};
    tbl[8] = '{0, 0, 'h81, 1, 2, 'h81};

    // Reset state
    do_reset(3);
    chk("reset_outputs", {de_o, c1_o, c0_o, q_o, locked_o}, 0);
    chk("reset_offset", int'(offset_o), 0);

    // Offset 0: 16 blanking tokens, lock on the 8th, then table of bytes/tokens
    delay = 0;
    for (int i = 0; i < 16; i++) begin
      send(1'b1, 0, 0);
      if (i == 8) chk("t1_not_locked_yet", int'(locked_o), 0);
      if (i == 9) chk("t1_locked_after_8th", int'(locked_o), 1);
    end
    for (int i = 0; i < 11; i++) begin
      if (i < 9) send(tbl[i].ctl, tbl[i].c, tbl[i].b);
      else       send(1'b1, 2, 0);
      if (i >= 2) begin
        got = (int'(de_o) << 10) | (int'({c1_o, c0_o}) << 8) | int'(q_o);
        chk($sformatf("t1_vec%0d", i - 2), got,
            (tbl[i-2].de << 10) | (tbl[i-2].cc << 8) | tbl[i-2].q);
      end
    end

    // Stream delayed by 7 bits: slips every ST cycles, lock at offset 7
    do_reset(2);
    delay = 7;
    for (int i = 0; i < 4000; i++) begin
      line_step();
      if (i == 1599) chk("t2_offset_mid", int'(offset_o), 3);
    end
    chk("t2_locked", int'(locked_o), 1);
    chk("t2_offset7", int'(offset_o), 7);
    for (int i = 0; i < 10; i++) send(1'b1, 0, 0);
    cap_en = 1;
    for (int i = 0; i < 32; i++) begin
      b = int'($urandom_range(0, 255));
      srcq.push_back(b);
      send(1'b0, 0, b);
    end
    for (int i = 0; i < 4; i++) send(1'b1, 0, 0);
    cap_en = 0;
    chk("t2_byte_count", capq.size(), srcq.size());
    for (int i = 0; i < srcq.size() && i < capq.size(); i++)
      chk($sformatf("t2_byte%0d", i), capq[i], srcq[i]);

    // Control codes tracked and held through the following data run
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 3; i++) send(1'b1, c, 0);
      chk($sformatf("t3_token_c%0d", c), int'({de_o, c1_o, c0_o}), c);
      for (int i = 0; i < 3; i++) send(1'b0, 0, int'($urandom_range(0, 255)));
      chk($sformatf("t3_held_c%0d", c), int'({de_o, c1_o, c0_o}), 4 | c);
    end

    // Loss of lock after LS data words without a token
    for (int i = 0; i < 4; i++) send(1'b1, 1, 0);
    for (int i = 0; i < LS + 1; i++) send(1'b0, 0, 'h00);
    chk("t4_still_locked", int'(locked_o), 1);
    send(1'b0, 0, 'h00);
    chk("t4_lock_lost", int'(locked_o), 0);
    chk("t4_outputs_zero", {de_o, c1_o, c0_o, q_o}, 0);
    chk("t4_offset_kept", int'(offset_o), 7);
`ifdef TMDS_DECODER_STATS_EN
    chk("t4_loss_cnt", int'(loss_cnt_o), 1);
`endif

    // Random noise: never locks, offset wraps 9 -> 0
    do_reset(2);
    wrapped  = 0;
    prev_off = 0;
    for (int i = 0; i < 10 * ST + 200; i++) begin
      tick(10'($urandom_range(0, 1023)), 1'b0);
      if (prev_off == 9 && offset_o == 4'd0) wrapped = 1;
      prev_off = int'(offset_o);
    end
    chk("t5_offset_wrapped", int'(wrapped), 1);
    chk("t5_never_locked", int'(locked_o), 0);

    // Reset while locked at offset 4, then reacquire from offset 0
    do_reset(2);
    delay = 4;
    for (int i = 0; i < 6 * ST && locked_o !== 1'b1; i++) line_step();
    chk("t6_locked", int'(locked_o), 1);
    chk("t6_offset4", int'(offset_o), 4);
    tick(10'h000, 1'b1);
    chk("t6_reset_outputs", {de_o, c1_o, c0_o, q_o, locked_o}, 0);
    chk("t6_reset_offset", int'(offset_o), 0);
    s_prev = 0; line_pos = 0;
    for (int i = 0; i < 6 * ST && locked_o !== 1'b1; i++) line_step();
    chk("t6_relocked", int'(locked_o), 1);
    chk("t6_relock_offset4", int'(offset_o), 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
